mtm_alu_host: RTL

- Host-side initiator for the mtm_Alu serial protocol.
- Accepts a parallel command (A, B, OP), frames it and drives it bit-serially onto the ALU's `sin` line.
- Then receives and decodes the ALU's response from `sout` and presents it as a parallel result with a one-cycle valid pulse.
- Used as the stimulus/response engine in the ALU test top and as the reusable host for any block that talks to the ALU.

---
 rtl/mtm_alu_host.sv | 238 +++++++++++++++++++++++
 1 files changed

// File: rtl/mtm_alu_host.sv
// mtm_alu_host: host-side initiator for the mtm_Alu serial protocol.
// Frames {B, A, OP, CRC4} onto alu_sin, then decodes the alu_sout reply.
// Ports: clk, rst_n (sync, active low)
//   cmd_valid/cmd_ready, cmd_a, cmd_b, cmd_op, cmd_bad_crc : command side
//   alu_sin (to ALU sin), alu_sout (from ALU sout)             : serial side
//   rsp_valid, rsp_c, rsp_flags, rsp_err, rsp_err_flags,
//   rsp_frame_err, rsp_timeout                                 : response side
module mtm_alu_host #(
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [31:0] cmd_a,
   input  logic [31:0] cmd_b,
   input  logic [2:0]  cmd_op,
   input  logic        cmd_bad_crc,
   output logic        alu_sin,
   input  logic        alu_sout,
   output logic        rsp_valid,
   output logic [31:0] rsp_c,
   output logic [3:0]  rsp_flags,
   output logic        rsp_err,
   output logic [5:0]  rsp_err_flags,
   output logic        rsp_frame_err,
   output logic        rsp_timeout
);

   typedef enum logic [2:0] {
      S_IDLE, S_TX, S_WAIT, S_RX, S_DONE
   } state_t;

   localparam logic [31:0] LP_TO_LAST = 32'(TIMEOUT_CYCLES - 1);

   function automatic logic [3:0] f_crc4(input logic [67:0] d);
      logic [3:0] c;
      logic       fb;
      c = 4'b0000;
      for (int i = 67; i >= 0; i--) begin
         fb = c[3] ^ d[i];
         c  = {c[2:0], 1'b0} ^ ({4{fb}} & 4'b0011);
      end
      return c;
   endfunction

   function automatic logic [2:0] f_crc3(input logic [36:0] d);
      logic [2:0] c;
      logic       fb;
      c = 3'b000;
      for (int i = 36; i >= 0; i--) begin
         fb = c[2] ^ d[i];
         c  = {c[1:0], 1'b0} ^ ({3{fb}} & 3'b011);
      end
      return c;
   endfunction

   function automatic logic [10:0] f_frame(input logic t, input logic [7:0] d);
      return {1'b0, t, d, 1'b1};
   endfunction

   state_t      r_state;
   logic        r_sin;
   logic        r_ready;
   logic [98:0] r_tx;
   logic [6:0]  r_cnt;
   logic [31:0] r_to;
   logic        r_hunt;
   logic [3:0]  r_bit;
   logic [2:0]  r_fidx;
   logic [8:0]  r_sh;
   logic [31:0] r_acc;
   logic        r_vld;
   logic [31:0] r_c;
   logic [3:0]  r_flags;
   logic        r_err;
   logic [5:0]  r_eflags;
   logic        r_ferr;
   logic        r_tout;

   logic [3:0]  w_crc4;
   logic [98:0] w_pkt;
   logic        w_type;
   logic [7:0]  w_byte;
   logic [2:0]  w_crc3;
   logic        w_to;
   logic        w_stop;
   logic        w_done;
   logic [31:0] w_c;
   logic [3:0]  w_flags;
   logic        w_err;
   logic [5:0]  w_eflags;
   logic        w_ferr;
   logic        w_tout;

   assign w_crc4 = f_crc4({cmd_b, cmd_a, 1'b1, cmd_op}) ^ {4{cmd_bad_crc}};
   assign w_pkt  = {f_frame(1'b0, cmd_b[31:24]), f_frame(1'b0, cmd_b[23:16]),
                    f_frame(1'b0, cmd_b[15:8]),  f_frame(1'b0, cmd_b[7:0]),
                    f_frame(1'b0, cmd_a[31:24]), f_frame(1'b0, cmd_a[23:16]),
                    f_frame(1'b0, cmd_a[15:8]),  f_frame(1'b0, cmd_a[7:0]),
                    f_frame(1'b1, {1'b0, cmd_op, w_crc4})};

   // r_sh holds {type, d7..d0} once the stop bit is on alu_sout
   assign w_type = r_sh[8];
   assign w_byte = r_sh[7:0];
   assign w_crc3 = f_crc3({r_acc, 1'b0, w_byte[6:3]});
   assign w_to   = (r_to >= LP_TO_LAST);
   assign w_stop = (r_state == S_RX) && !r_hunt && (r_bit == 4'd9);

   always_comb begin
      w_done   = 1'b0;
      w_c      = r_acc;
      w_flags  = 4'b0000;
      w_err    = 1'b0;
      w_eflags = 6'b000000;
      w_ferr   = 1'b0;
      w_tout   = 1'b0;
      if (w_stop) begin
         if (!alu_sout) begin
            w_done = 1'b1;
            w_ferr = 1'b1;
         end else if ((r_fidx == 3'd0) && w_type) begin
            w_done   = 1'b1;
            w_c      = 32'h0;
            w_err    = 1'b1;
            w_eflags = w_byte[6:1];
            w_ferr   = (w_byte[0] != ^w_byte[7:1]) | !w_byte[7];
         end else if ((r_fidx == 3'd4) && w_type) begin
            w_done  = 1'b1;
            w_flags = w_byte[6:3];
            w_ferr  = (w_crc3 != w_byte[2:0]) | w_byte[7];
         end else if ((r_fidx == 3'd4) || w_type) begin
            w_done = 1'b1;
            w_ferr = 1'b1;
         end
      end
      // a response finishing on the last allowed cycle still counts
      if (!w_done && w_to &&
          ((r_state == S_WAIT) || (r_state == S_RX))) begin
         w_done = 1'b1;
         w_c    = 32'h0;
         w_tout = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state  <= S_IDLE;
         r_sin    <= 1'b1;
         r_ready  <= 1'b1;
         r_tx     <= '0;
         r_cnt    <= 7'd0;
         r_to     <= 32'd0;
         r_hunt   <= 1'b0;
         r_bit    <= 4'd0;
         r_fidx   <= 3'd0;
         r_sh     <= 9'd0;
         r_acc    <= 32'h0;
         r_vld    <= 1'b0;
         r_c      <= 32'h0;
         r_flags  <= 4'b0000;
         r_err    <= 1'b0;
         r_eflags <= 6'b000000;
         r_ferr   <= 1'b0;
         r_tout   <= 1'b0;
      end else begin
         r_vld <= 1'b0;
         if ((r_state == S_WAIT) || (r_state == S_RX))
            r_to <= r_to + 32'd1;
         if (w_done) begin
            r_state  <= S_DONE;
            r_vld    <= 1'b1;
            r_c      <= w_c;
            r_flags  <= w_flags;
            r_err    <= w_err;
            r_eflags <= w_eflags;
            r_ferr   <= w_ferr;
            r_tout   <= w_tout;
         end else begin
            unique case (r_state)
               S_IDLE: if (cmd_valid) begin
                  r_ready <= 1'b0;
                  r_sin   <= w_pkt[98];
                  r_tx    <= {w_pkt[97:0], 1'b1};
                  r_cnt   <= 7'd1;
                  r_state <= S_TX;
               end
               S_TX: if (r_cnt == 7'd99) begin
                  r_sin   <= 1'b1;
                  r_to    <= 32'd1;
                  r_state <= S_WAIT;
               end else begin
                  r_sin <= r_tx[98];
                  r_tx  <= {r_tx[97:0], 1'b1};
                  r_cnt <= r_cnt + 7'd1;
               end
               S_WAIT: if (!alu_sout) begin
                  r_state <= S_RX;
                  r_hunt  <= 1'b0;
                  r_bit   <= 4'd0;
                  r_fidx  <= 3'd0;
                  r_acc   <= 32'h0;
               end
               S_RX: if (r_hunt) begin
                  if (!alu_sout) begin
                     r_hunt <= 1'b0;
                     r_bit  <= 4'd0;
                  end
               end else if (w_stop) begin
                  // only a good data frame gets here
                  r_acc  <= {r_acc[23:0], w_byte};
                  r_fidx <= r_fidx + 3'd1;
                  r_hunt <= 1'b1;
               end else begin
                  r_sh  <= {r_sh[7:0], alu_sout};
                  r_bit <= r_bit + 4'd1;
               end
               S_DONE: begin
                  r_ready <= 1'b1;
                  r_state <= S_IDLE;
               end
               default: r_state <= S_IDLE;
            endcase
         end
      end
   end

   assign cmd_ready     = r_ready;
   assign alu_sin       = r_sin;
   assign rsp_valid     = r_vld;
   assign rsp_c         = r_c;
   assign rsp_flags     = r_flags;
   assign rsp_err       = r_err;
   assign rsp_err_flags = r_eflags;
   assign rsp_frame_err = r_ferr;
   assign rsp_timeout   = r_tout;

endmodule
